// File: rtl/gpr_cdb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// gpr_cdb_arbiter_pkg
// Shared types and constants for the GPR common data bus.
//   ROB_WIDTH  : width of a reorder-buffer tag
//   CDB_DATA_W : width of a broadcast result
//   CDB_*      : requester slot assignment on the GPR CDB (index 0 = highest
//                fixed priority)
//   cdb_t      : broadcast record as consumed by reservation stations / ROB
// ---------------------------------------------------------------------------
package gpr_cdb_arbiter_pkg;

   localparam int ROB_WIDTH  = 6;
   localparam int CDB_DATA_W = 32;

   localparam int unsigned CDB_MOV  = 0;
   localparam int unsigned CDB_ALU  = 1;
   localparam int unsigned CDB_FPU  = 2;
   localparam int unsigned CDB_LOAD = 3;

   typedef struct packed {
      logic                  valid;
      logic [ROB_WIDTH-1:0]  tag;
      logic [CDB_DATA_W-1:0] data;
   } cdb_t;

endpackage

// File: rtl/gpr_cdb_arbiter_if.sv
// ---------------------------------------------------------------------------
// gpr_cdb_arbiter_if
// Bundle between the execution units (master side) and the CDB arbiter
// (slave side).
//   req_valid / req_tag / req_data : per-unit request, tag and result
//   req_ready                      : per-unit grant (one-hot or zero)
//   cdb_block                      : slot reservation, suppresses any grant
//   cdb_valid / cdb_tag / cdb_data : registered broadcast
//
// Handshake: a unit raises req_valid[i] with req_tag[i] and keeps both
// stable until it sees req_ready[i]==1 in the same cycle; the transfer
// happens on that clock edge. The unit then presents its result on
// req_data[i] during the following cycle, when the broadcast is valid.
// req_ready never depends on the cdb_* outputs.
// ---------------------------------------------------------------------------
interface gpr_cdb_arbiter_if #(
   parameter int N_REQ = 4
);
   import gpr_cdb_arbiter_pkg::*;

   logic [N_REQ-1:0]                  req_valid;
   logic [N_REQ-1:0][ROB_WIDTH-1:0]   req_tag;
   logic [N_REQ-1:0][CDB_DATA_W-1:0]  req_data;
   logic [N_REQ-1:0]                  req_ready;
   logic                              cdb_block;
   logic                              cdb_valid;
   logic [ROB_WIDTH-1:0]              cdb_tag;
   logic [CDB_DATA_W-1:0]             cdb_data;

   modport master (
      output req_valid, req_tag, req_data, cdb_block,
      input  req_ready, cdb_valid, cdb_tag, cdb_data
   );

   modport slave (
      input  req_valid, req_tag, req_data, cdb_block,
      output req_ready, cdb_valid, cdb_tag, cdb_data
   );

endinterface

// File: rtl/gpr_cdb_arbiter_prio_age_pick.sv
// ---------------------------------------------------------------------------
// gpr_cdb_arbiter_prio_age_pick
// Combinational N_REQ-way picker: fixed priority (index 0 highest), with
// starved requesters forming a higher-priority class of their own.
//   valid_i   : request vector
//   starved_i : requester has waited the maximum number of cycles
//   block_i   : suppress any grant this cycle
//   grant_o   : one-hot or zero grant
//   idx_o     : encoded winner (0 when there is no grant)
//   any_o     : a grant was made
// ---------------------------------------------------------------------------
module gpr_cdb_arbiter_prio_age_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] valid_i,
   input  logic [N_REQ-1:0] starved_i,
   input  logic             block_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   logic [N_REQ-1:0] cand;

   always_comb begin
      cand    = '0;
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;

      // Starved requesters, if any are asking, exclude everyone else.
      if (!block_i) begin
         cand = (|(valid_i & starved_i)) ? (valid_i & starved_i) : valid_i;
      end

      // Scan from the top so the lowest set index is the last one written.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (cand[i]) begin
            idx_o = IDX_W'(i);
         end
      end

      any_o = |cand;
      if (any_o) begin
         grant_o[idx_o] = 1'b1;
      end
   end

endmodule

// File: rtl/gpr_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// gpr_cdb_arbiter
// Shares the GPR common data bus among the mov, alu, fpu-to-gpr and load
// reservation stations. One grant per cycle, broadcast one cycle later.
//   clk          : clock
//   reset        : synchronous, active-low
//   bus          : gpr_cdb_arbiter_if slave modport (requests, grants,
//                  slot block, broadcast); its N_REQ must match this one
//   dbg_wait_cnt : per-requester aging counters, for observation only
// ---------------------------------------------------------------------------
module gpr_cdb_arbiter
   import gpr_cdb_arbiter_pkg::*;
#(
   parameter  int N_REQ        = 4,
   parameter  int STARVE_LIMIT = 3,
   localparam int CW           = $clog2(STARVE_LIMIT + 1),
   localparam int IDX_W        = $clog2(N_REQ)
) (
   input  logic                     clk,
   input  logic                     reset,
   gpr_cdb_arbiter_if.slave         bus,
   output logic [N_REQ-1:0][CW-1:0] dbg_wait_cnt
);

   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [N_REQ-1:0][CW-1:0] wait_cnt_q, wait_cnt_d;
   logic                     cdb_valid_q, cdb_valid_d;
   logic [ROB_WIDTH-1:0]     cdb_tag_q, cdb_tag_d;
   logic [IDX_W-1:0]         grant_idx_q, grant_idx_d;

   logic [N_REQ-1:0]         starved;
   logic [N_REQ-1:0]         grant_oh;
   logic [IDX_W-1:0]         pick_idx;
   logic                     pick_any;
   cdb_t                     cdb_out;

   always_comb begin
      starved = '0;
      for (int i = 0; i < N_REQ; i++) begin
         starved[i] = (wait_cnt_q[i] == LIMIT);
      end
   end

   // Holding reset low behaves like a blocked slot, so no grant leaks out
   // while the arbiter is being reset.
   gpr_cdb_arbiter_prio_age_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .valid_i   (bus.req_valid),
      .starved_i (starved),
      .block_i   (bus.cdb_block | ~reset),
      .grant_o   (grant_oh),
      .idx_o     (pick_idx),
      .any_o     (pick_any)
   );

   assign bus.req_ready = grant_oh;

   always_comb begin
      wait_cnt_d  = wait_cnt_q;
      cdb_valid_d = pick_any;
      cdb_tag_d   = cdb_tag_q;
      grant_idx_d = grant_idx_q;

      // Aging: a denied requester counts up and sticks at the limit; a
      // granted or idle requester starts over.
      for (int i = 0; i < N_REQ; i++) begin
         if (bus.req_valid[i] && !grant_oh[i]) begin
            wait_cnt_d[i] = (wait_cnt_q[i] == LIMIT) ? LIMIT
                                                     : wait_cnt_q[i] + CW'(1);
         end else begin
            wait_cnt_d[i] = '0;
         end
      end

      // The tag and the data-select index only move on a grant; an idle
      // cycle leaves the last broadcast tag on the bus.
      if (pick_any) begin
         cdb_tag_d   = bus.req_tag[pick_idx];
         grant_idx_d = pick_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wait_cnt_q  <= '0;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         grant_idx_q <= '0;
      end else begin
         wait_cnt_q  <= wait_cnt_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_tag_q   <= cdb_tag_d;
         grant_idx_q <= grant_idx_d;
      end
   end

   // The winning unit registers its result on the grant edge, so the data
   // is taken straight from its output rather than captured here.
   always_comb begin
      cdb_out.valid = cdb_valid_q;
      cdb_out.tag   = cdb_tag_q;
      cdb_out.data  = bus.req_data[grant_idx_q];
   end

   assign bus.cdb_valid = cdb_out.valid;
   assign bus.cdb_tag   = cdb_out.tag;
   assign bus.cdb_data  = cdb_out.data;
   assign dbg_wait_cnt  = wait_cnt_q;

endmodule

// File: tb/tb_gpr_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gpr_cdb_arbiter
// Self-checking bench for gpr_cdb_arbiter (N_REQ=4, STARVE_LIMIT=3).
// Each cycle the bench predicts the grant from the request vector and its
// own per-requester wait counts, and keeps the expected broadcasts in a
// queue. Vectors, hand-written sequences and random traffic all run through
// the same cycle task.
// ---------------------------------------------------------------------------
module tb_gpr_cdb_arbiter;
   import gpr_cdb_arbiter_pkg::*;

   localparam int N     = 4;
   localparam int LIMIT = 3;
   localparam int CW    = 2;
   localparam int EW    = ROB_WIDTH + CDB_DATA_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   gpr_cdb_arbiter_if #(.N_REQ(N)) bus ();
   logic [N-1:0][CW-1:0] dbg_wait_cnt;

   gpr_cdb_arbiter #(
      .N_REQ        (N),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .dbg_wait_cnt (dbg_wait_cnt)
   );

   // ---------------- scoreboard state ----------------
   int              checks   = 0;
   int              failures = 0;
   int              m_wait[N];
   logic [ROB_WIDTH-1:0] m_tag;
   bit              model_known = 1'b0;
   logic [EW-1:0]   exp_q[$];
   logic [31:0]     next_data;
   int              last_grant;
   logic [N-1:0]    last_ready;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Winner from the rules: nothing when blocked, in reset or idle; else the
   // lowest requester that has waited LIMIT cycles; else the lowest one.
   function automatic int model_pick(input logic [N-1:0] v, input logic blk, input logic rst_n);
      if (!rst_n || blk || v == '0) return -1;
      for (int i = 0; i < N; i++) if (v[i] && m_wait[i] >= LIMIT) return i;
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Called with inputs driven at posedge+1; returns at the next posedge+1.
   task automatic cycle(input string name);
      int            w;
      logic [N-1:0]  exp_ready;
      logic [EW-1:0] e;
      #1;
      w = model_pick(bus.req_valid, bus.cdb_block, reset);
      exp_ready = '0;
      if (w >= 0) exp_ready[w] = 1'b1;
      last_ready = bus.req_ready;
      last_grant = w;
      chk({name, " req_ready"}, 64'(bus.req_ready), 64'(exp_ready));
      if (model_known) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({name, " cdb_valid"}, 64'(bus.cdb_valid), 64'(1));
            chk({name, " cdb_tag_data"}, 64'({bus.cdb_tag, bus.cdb_data}), 64'(e));
         end else begin
            chk({name, " cdb_valid"}, 64'(bus.cdb_valid), 64'(0));
            chk({name, " cdb_tag_hold"}, 64'(bus.cdb_tag), 64'(m_tag));
         end
         for (int i = 0; i < N; i++)
            chk({name, " wait_cnt"}, 64'(dbg_wait_cnt[i]), 64'(m_wait[i]));
      end
      @(posedge clk);
      if (!reset) begin
         for (int i = 0; i < N; i++) m_wait[i] = 0;
         m_tag = '0;
         model_known = 1'b1;
         exp_q.delete();
      end else begin
         for (int i = 0; i < N; i++) begin
            if (bus.req_valid[i] && i != w)
               m_wait[i] = (m_wait[i] + 1 > LIMIT) ? LIMIT : m_wait[i] + 1;
            else
               m_wait[i] = 0;
         end
         if (w >= 0) m_tag = bus.req_tag[w];
      end
      #1;
      if (w >= 0) begin
         bus.req_data[w] = next_data;
         exp_q.push_back({m_tag, next_data});
      end
      next_data = $urandom();
   endtask

   task automatic idle();
      bus.req_valid = '0;
      bus.cdb_block = 1'b0;
      cycle("idle");
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [N-1:0]         v;
      logic                 blk;
      logic [N-1:0]         exp_ready;
      logic [ROB_WIDTH-1:0] exp_tag;
   } vec_t;

   vec_t vecs[8];

   int exp_g_cont[5] = '{0, 0, 0, 1, 0};
   int exp_t_cont[5] = '{1, 1, 1, 2, 1};
   int exp_g_two[6]  = '{0, 0, 0, 1, 3, 0};

   initial begin
      vecs[0] = '{4'b0001, 1'b0, 4'b0001, 6'd10};
      vecs[1] = '{4'b0110, 1'b0, 4'b0010, 6'd11};
      vecs[2] = '{4'b1000, 1'b0, 4'b1000, 6'd13};
      vecs[3] = '{4'b1111, 1'b0, 4'b0001, 6'd10};
      vecs[4] = '{4'b1100, 1'b0, 4'b0100, 6'd12};
      vecs[5] = '{4'b0000, 1'b0, 4'b0000, 6'd0};
      vecs[6] = '{4'b1111, 1'b1, 4'b0000, 6'd0};
      vecs[7] = '{4'b1010, 1'b0, 4'b0010, 6'd11};

      reset         = 1'b0;
      bus.req_valid = '0;
      bus.req_tag   = '0;
      bus.req_data  = '0;
      bus.cdb_block = 1'b0;
      next_data     = $urandom();
      for (int i = 0; i < N; i++) m_wait[i] = 0;
      m_tag = '0;
      @(posedge clk);
      #1;

      // Reset held with every unit requesting: no grants.
      bus.req_valid = 4'b1111;
      for (int k = 0; k < 2; k++) begin
         cycle("reset_hold");
         chk("reset req_ready", 64'(last_ready), 64'(0));
      end
      reset = 1'b1;
      bus.req_valid = '0;
      cycle("post_reset");
      #1;
      chk("reset cdb_valid", 64'(bus.cdb_valid), 64'(0));

      // Single request from unit 2.
      idle();
      bus.req_valid = 4'b0100;
      bus.req_tag[2] = 6'd5;
      next_data = 32'hDEADBEEF;
      cycle("single");
      chk("single ready", 64'(last_ready), 64'(4'b0100));
      bus.req_valid = '0;
      #1;
      chk("single cdb_valid", 64'(bus.cdb_valid), 64'(1));
      chk("single cdb_tag", 64'(bus.cdb_tag), 64'(5));
      chk("single cdb_data", 64'(bus.cdb_data), 64'(32'hDEADBEEF));
      cycle("single_after");

      // Contention between units 0 and 1.
      idle();
      bus.req_valid = 4'b0011;
      bus.req_tag[0] = 6'd1;
      bus.req_tag[1] = 6'd2;
      for (int k = 0; k < 5; k++) begin
         cycle("contention");
         chk("contention grant", 64'(last_grant), 64'(exp_g_cont[k]));
         #1;
         chk("contention cdb_tag", 64'(bus.cdb_tag), 64'(exp_t_cont[k]));
      end

      // Blocked slot: unit 3 ages to the limit, then beats unit 0.
      idle();
      bus.cdb_block = 1'b1;
      bus.req_valid = 4'b1000;
      bus.req_tag[3] = 6'd7;
      for (int k = 0; k < 5; k++) begin
         cycle("block");
         chk("block ready", 64'(last_ready), 64'(0));
      end
      chk("block wait_cnt sat", 64'(dbg_wait_cnt[3]), 64'(3));
      bus.cdb_block = 1'b0;
      bus.req_valid = 4'b1001;
      bus.req_tag[0] = 6'd1;
      cycle("unblock");
      chk("unblock grant", 64'(last_grant), 64'(3));
      #1;
      chk("unblock cdb_tag", 64'(bus.cdb_tag), 64'(7));
      bus.req_valid = 4'b0001;
      cycle("unblock_after");

      // Two starved units under unit 0 pressure.
      idle();
      bus.req_valid = 4'b1011;
      bus.req_tag[0] = 6'd1;
      bus.req_tag[1] = 6'd2;
      bus.req_tag[3] = 6'd7;
      for (int k = 0; k < 6; k++) begin
         cycle("two_starved");
         chk("two_starved grant", 64'(last_grant), 64'(exp_g_two[k]));
         if (k == 3) chk("two_starved keep sat", 64'(dbg_wait_cnt[3]), 64'(3));
      end

      // Reset in the middle of traffic.
      idle();
      bus.req_valid = 4'b0101;
      bus.req_tag[0] = 6'd1;
      bus.req_tag[2] = 6'd4;
      cycle("pre_reset");
      reset = 1'b0;
      bus.req_valid = 4'b0100;
      cycle("mid_reset");
      chk("mid_reset ready", 64'(last_ready), 64'(0));
      #1;
      chk("mid_reset cdb_valid", 64'(bus.cdb_valid), 64'(0));
      chk("mid_reset counters", 64'(dbg_wait_cnt), 64'(0));
      reset = 1'b1;
      cycle("after_reset");
      chk("after_reset grant", 64'(last_grant), 64'(2));
      #1;
      chk("after_reset cdb_valid", 64'(bus.cdb_valid), 64'(1));
      chk("after_reset cdb_tag", 64'(bus.cdb_tag), 64'(4));

      // Vector table, each vector from cleared counters.
      for (int i = 0; i < N; i++) bus.req_tag[i] = ROB_WIDTH'(10 + i);
      for (int k = 0; k < 8; k++) begin
         idle();
         bus.req_valid = vecs[k].v;
         bus.cdb_block = vecs[k].blk;
         cycle("vec");
         chk("vec ready", 64'(last_ready), 64'(vecs[k].exp_ready));
         #1;
         chk("vec cdb_valid", 64'(bus.cdb_valid), 64'(vecs[k].exp_ready != '0));
         if (vecs[k].exp_ready != '0)
            chk("vec cdb_tag", 64'(bus.cdb_tag), 64'(vecs[k].exp_tag));
      end
      idle();

      // Random traffic; requesters mostly hold until granted.
      for (int c = 0; c < 500; c++) begin
         for (int i = 0; i < N; i++) begin
            if (bus.req_valid[i]) begin
               if (last_grant == i) begin
                  bus.req_valid[i] = ($urandom_range(0, 1) == 1);
                  bus.req_tag[i]   = ROB_WIDTH'($urandom());
               end else if ($urandom_range(0, 19) == 0) begin
                  bus.req_valid[i] = 1'b0;
               end
            end else if ($urandom_range(0, 2) == 0) begin
               bus.req_valid[i] = 1'b1;
               bus.req_tag[i]   = ROB_WIDTH'($urandom());
            end
         end
         bus.cdb_block = ($urandom_range(0, 4) == 0);
         reset = ($urandom_range(0, 99) != 0);
         cycle("rand");
      end
      reset = 1'b1;
      idle();
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gpr_cdb_arbiter.md
Name: gpr_cdb_arbiter

Overview:
- Shares the single GPR common data bus (CDB) among the out-of-order execution units: mov, alu, fpu-to-gpr and load reservation stations.
- Each unit raises a request with its ROB tag. The arbiter grants at most one per cycle and drives the registered broadcast (valid, tag, data) seen by every reservation station and the ROB.
- Policy is fixed priority (index 0 highest) with starvation aging, plus a slot-blocking input for fixed-latency returns.

Parameters:
- N_REQ, 4, number of requesting units (2..8).
- STARVE_LIMIT, 3, consecutive denied cycles after which a requester is promoted (1..15).
- ROB_WIDTH, from common package, ROB tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset; 0 = reset asserted.
- req_valid  in  N_REQ  unit i has a result ready to broadcast.
- req_tag  in  N_REQ x ROB_WIDTH  ROB tag of unit i, valid in the same cycle as req_valid.
- req_data  in  N_REQ x 32  result of unit i; sampled the cycle after grant (unit registers result on its grant edge).
- req_ready  out  N_REQ  one-hot-or-zero grant, combinational in the request cycle.
- cdb_block  in  1  when 1, no grant this cycle (slot reserved).
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  ROB_WIDTH  broadcast tag.
- cdb_data  out  32  broadcast data.

Behaviour:
- Reset (reset==0 at posedge):
  - cdb_valid<=0, cdb_tag<=0, grant_idx_q<=0, all wait_cnt<=0.
  - While reset==0, req_ready is all-zero combinationally.
  - Reset overrides any grant made in the same cycle.
- Grant in cycle t:
  - No grant if cdb_block==1 or no req_valid.
  - Else if any requester has wait_cnt==STARVE_LIMIT and req_valid, grant the lowest such index.
  - Else grant the lowest index with req_valid.
  - req_ready is one-hot on the winner; at most one bit is ever set.
- Broadcast at t+1 (posedge t registers):
  - cdb_valid<=1, cdb_tag<=req_tag[winner], grant_idx_q<=winner.
  - cdb_data = req_data[grant_idx_q], combinational mux from the unit's registered result.
  - With no grant, cdb_valid<=0; cdb_tag holds its old value; cdb_data is don't-care.
  - Latency: request to broadcast = 1 cycle. Back-to-back grants are allowed every cycle.
- Aging, per i at posedge:
  - If req_valid[i] && !req_ready[i], wait_cnt[i] <= min(wait_cnt[i]+1, STARVE_LIMIT).
  - Else wait_cnt[i] <= 0. Dropping the request or being granted clears it.
  - Saturates; never wraps. Counter width is clog2(STARVE_LIMIT+1).
- cdb_block:
  - Counters still age during block cycles, but saturate.
  - A requester at the limit wins on the first unblocked cycle.
- Simultaneous events:
  - Multiple requesters at the limit: lowest index wins; the others keep the saturated count.
  - A requester at the limit that drops req_valid is cleared, with no grant.
- Requester contract:
  - Holds req_valid and req_tag stable until granted.
  - The arbiter does not check this.
- No internal FSM beyond the counters and the one-cycle broadcast register; no combinational path from cdb_* to req_ready.

Decomposition:
- Shared package (common.vh): cdb_t typedef {valid, tag, data}, ROB_WIDTH, unit index constants (CDB_MOV, CDB_ALU, CDB_FPU, CDB_LOAD).
- Outputs are packed as a cdb_t to match the reservation-station input type.
- One sub-module, prio_age_pick: combinational N_REQ-way picker (valid vector + starved vector + block → one-hot grant + encoded index), reusable for the FPR CDB arbiter.

Test Plan (N_REQ=4, STARVE_LIMIT=3):
- Reset held low 2 cycles with req_valid=4'b1111 -> req_ready=0 throughout; after release, cdb_valid=0 until the first grant cycle ends.
- Single request: req_valid[2]=1, tag=5, data next cycle 0xDEADBEEF -> req_ready=4'b0100 same cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_data=0xDEADBEEF.
- Contention: req_valid=4'b0011 held with units 0/1 always re-requesting (tags 1/2) -> grants 0,0,0 then 1 on cycle 4 (wait_cnt[1] hit 3), then 0; cdb_tag sequence 1,1,1,2,1.
- Block: cdb_block=1 for 5 cycles with req_valid[3]=1 (tag 7) -> no grants, wait_cnt[3] saturates at 3; first unblocked cycle grants 3 even with req_valid[0]=1; cdb_tag=7.
- Two starved units: units 1 and 3 both reach limit under unit 0 pressure -> unit 1 granted first, unit 3 next cycle (still saturated), then unit 0.
- Reset mid-operation: grant to unit 2 at cycle t, reset=0 at t -> at t+1 cdb_valid=0, counters 0; a re-request after release is granted normally.
